// File: rtl/bbc_csr_pkg.sv
// Shared CSR bus definitions for the BBC CSR request arbiter: state encoding,
// request/response field widths and the forced-completion read pattern.
package bbc_csr_pkg;

    localparam int SELECT_W = 16;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;

    localparam logic [DATA_W-1:0] TIMEOUT_READ_DATA = 32'hDEAD_C5A0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                valid;
        logic                read_not_write;
        logic [SELECT_W-1:0] select;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
    } csr_request_t;

endpackage

// File: rtl/csr_arb_timeout.sv
// Transaction watchdog for csr_request_arbiter: counts busy cycles since the
// last grant, flags expiry and keeps a saturating count of expired transactions.
module csr_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       active,
    input  logic       done,
    output logic       expire,
    output logic [7:0] timeout_count
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cycle_cnt_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_p1 <= '0;
        end else if (start) begin
            cycle_cnt_p1 <= '0;
        end else if (active) begin
            cycle_cnt_p1 <= cycle_cnt_p1 + 16'd1;
        end
    end

    // A genuine completion in the expiry cycle takes priority over forcing one.
    assign expire = active && !done && (cycle_cnt_p1 == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_count <= '0;
        end else if (expire && (timeout_count != 8'hFF)) begin
            timeout_count <= timeout_count + 8'd1;
        end
    end

endmodule

// File: rtl/csr_request_arbiter.sv
// Round-robin arbiter sharing the BBC CSR port between two requesters.
// Optional watchdog with forced completion: define CSR_REQUEST_ARBITER_TIMEOUT_EN.
module csr_request_arbiter
    import bbc_csr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_csr_request__valid,
    input  logic        req0_csr_request__read_not_write,
    input  logic [15:0] req0_csr_request__select,
    input  logic [15:0] req0_csr_request__address,
    input  logic [31:0] req0_csr_request__data,
    output logic        req0_csr_response__ack,
    output logic        req0_csr_response__read_data_valid,
    output logic [31:0] req0_csr_response__read_data,

    input  logic        req1_csr_request__valid,
    input  logic        req1_csr_request__read_not_write,
    input  logic [15:0] req1_csr_request__select,
    input  logic [15:0] req1_csr_request__address,
    input  logic [31:0] req1_csr_request__data,
    output logic        req1_csr_response__ack,
    output logic        req1_csr_response__read_data_valid,
    output logic [31:0] req1_csr_response__read_data,

    output logic        csr_request__valid,
    output logic        csr_request__read_not_write,
    output logic [15:0] csr_request__select,
    output logic [15:0] csr_request__address,
    output logic [31:0] csr_request__data,
    input  logic        csr_response__ack,
    input  logic        csr_response__read_data_valid,
    input  logic [31:0] csr_response__read_data,

    output logic        busy,
    output logic [7:0]  timeout_count
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    arb_state_t   state_p1, state_nxt;
    logic         grant_p1, last_grant_p1;
    csr_request_t ds_req_p1;
    csr_request_t req0_pkt, req1_pkt;
    logic         grant_now, grant_sel, expire;
    logic         rsp_ack, rsp_rdv;
    logic [31:0]  rsp_data;

    assign req0_pkt = '{valid: 1'b1, read_not_write: req0_csr_request__read_not_write,
                        select: req0_csr_request__select, address: req0_csr_request__address,
                        data: req0_csr_request__data};
    assign req1_pkt = '{valid: 1'b1, read_not_write: req1_csr_request__read_not_write,
                        select: req1_csr_request__select, address: req1_csr_request__address,
                        data: req1_csr_request__data};

    assign grant_now = (state_p1 == IDLE) && (req0_csr_request__valid || req1_csr_request__valid);
    assign grant_sel = (req0_csr_request__valid && req1_csr_request__valid) ? ~last_grant_p1
                                                                          : req1_csr_request__valid;

`ifdef CSR_REQUEST_ARBITER_TIMEOUT_EN
    logic done;

    assign done = ((state_p1 == ISSUE) && csr_response__ack &&
                   (!ds_req_p1.read_not_write || csr_response__read_data_valid)) ||
                  ((state_p1 == WAIT_DATA) && csr_response__read_data_valid);

    csr_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk           (clk),
        .reset         (reset),
        .start         (grant_now),
        .active        (busy),
        .done          (done),
        .expire        (expire),
        .timeout_count (timeout_count)
    );
`else
    assign expire        = 1'b0;
    assign timeout_count = 8'd0;
`endif

    always_comb begin
        state_nxt = state_p1;
        case (state_p1)
            IDLE:      if (grant_now) state_nxt = ISSUE;
            ISSUE: begin
                if (csr_response__ack) begin
                    state_nxt = (!ds_req_p1.read_not_write || csr_response__read_data_valid)
                                ? IDLE : WAIT_DATA;
                end
            end
            WAIT_DATA: if (csr_response__read_data_valid) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (expire) state_nxt = IDLE;
    end

    // Stage p1: granted request registered toward the BBC bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p1      <= IDLE;
            grant_p1      <= 1'b0;
            last_grant_p1 <= 1'b1;
            ds_req_p1     <= '0;
        end else begin
            state_p1 <= state_nxt;
            if (grant_now) begin
                grant_p1      <= grant_sel;
                last_grant_p1 <= grant_sel;
                ds_req_p1     <= grant_sel ? req1_pkt : req0_pkt;
            end else if (((state_p1 == ISSUE) && csr_response__ack) || expire) begin
                ds_req_p1.valid <= 1'b0;
            end
        end
    end

    assign csr_request__valid          = ds_req_p1.valid;
    assign csr_request__read_not_write = ds_req_p1.read_not_write;
    assign csr_request__select         = ds_req_p1.select;
    assign csr_request__address        = ds_req_p1.address;
    assign csr_request__data           = ds_req_p1.data;
    assign busy                        = (state_p1 != IDLE);

    // Responses route combinationally, gated by registered state so IDLE drops them.
    always_comb begin
        rsp_ack  = (state_p1 == ISSUE) && csr_response__ack;
        rsp_rdv  = csr_response__read_data_valid &&
                   (((state_p1 == ISSUE) && ds_req_p1.read_not_write) || (state_p1 == WAIT_DATA));
        rsp_data = csr_response__read_data;
        if (expire) begin
            rsp_ack = rsp_ack || (state_p1 == ISSUE);
            if (ds_req_p1.read_not_write) begin
                rsp_rdv  = 1'b1;
                rsp_data = TIMEOUT_READ_DATA;
            end
        end
    end

    assign req0_csr_response__ack             = rsp_ack && !grant_p1;
    assign req0_csr_response__read_data_valid = rsp_rdv && !grant_p1;
    assign req0_csr_response__read_data       = rsp_data;
    assign req1_csr_response__ack             = rsp_ack && grant_p1;
    assign req1_csr_response__read_data_valid = rsp_rdv && grant_p1;
    assign req1_csr_response__read_data       = rsp_data;

endmodule

// File: tb/tb_csr_request_arbiter.sv
// Scoreboard bench for csr_request_arbiter: directed transactions push expected
// downstream requests and requester responses; a negedge monitor pops and compares.
module tb_csr_request_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_v, r0_rnw, r1_v, r1_rnw;
    logic [15:0] r0_sel, r0_addr, r1_sel, r1_addr;
    logic [31:0] r0_data, r1_data;
    logic        r0_ack, r0_rdv, r1_ack, r1_rdv;
    logic [31:0] r0_rdata, r1_rdata;
    logic        ds_v, ds_rnw;
    logic [15:0] ds_sel, ds_addr;
    logic [31:0] ds_data;
    logic        bbc_ack, bbc_rdv;
    logic [31:0] bbc_rdata;
    logic        busy;
    logic [7:0]  timeout_count;

    always #5 clk = ~clk;

    csr_request_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk                                (clk),
        .reset                              (reset),
        .req0_csr_request__valid            (r0_v),
        .req0_csr_request__read_not_write   (r0_rnw),
        .req0_csr_request__select           (r0_sel),
        .req0_csr_request__address          (r0_addr),
        .req0_csr_request__data             (r0_data),
        .req0_csr_response__ack             (r0_ack),
        .req0_csr_response__read_data_valid (r0_rdv),
        .req0_csr_response__read_data       (r0_rdata),
        .req1_csr_request__valid            (r1_v),
        .req1_csr_request__read_not_write   (r1_rnw),
        .req1_csr_request__select           (r1_sel),
        .req1_csr_request__address          (r1_addr),
        .req1_csr_request__data             (r1_data),
        .req1_csr_response__ack             (r1_ack),
        .req1_csr_response__read_data_valid (r1_rdv),
        .req1_csr_response__read_data       (r1_rdata),
        .csr_request__valid                 (ds_v),
        .csr_request__read_not_write        (ds_rnw),
        .csr_request__select                (ds_sel),
        .csr_request__address               (ds_addr),
        .csr_request__data                  (ds_data),
        .csr_response__ack                  (bbc_ack),
        .csr_response__read_data_valid      (bbc_rdv),
        .csr_response__read_data            (bbc_rdata),
        .busy                               (busy),
        .timeout_count                      (timeout_count)
    );

    typedef struct packed {
        logic        rnw;
        logic [15:0] sel;
        logic [15:0] addr;
        logic [31:0] data;
    } req_exp_t;

    typedef struct packed {
        logic        who;
        logic        ack;
        logic        rdv;
        logic [31:0] data;
    } rsp_exp_t;

    req_exp_t    exp_req_q[$];
    rsp_exp_t    exp_rsp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        cur_rnw[2];
    logic [15:0] cur_sel[2];
    logic [15:0] cur_addr[2];
    logic [31:0] cur_data[2];
    logic        prev_ds_v = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic set_req(input int who, input logic rnw, input logic [15:0] sel,
                           input logic [15:0] addr, input logic [31:0] data);
        cur_rnw[who] = rnw; cur_sel[who] = sel; cur_addr[who] = addr; cur_data[who] = data;
        if (who == 0) begin
            r0_v = 1'b1; r0_rnw = rnw; r0_sel = sel; r0_addr = addr; r0_data = data;
        end else begin
            r1_v = 1'b1; r1_rnw = rnw; r1_sel = sel; r1_addr = addr; r1_data = data;
        end
    endtask

    task automatic drop_req(input int who);
        if (who == 0) r0_v = 1'b0;
        else          r1_v = 1'b0;
    endtask

    task automatic expect_req(input int who);
        exp_req_q.push_back(req_exp_t'{cur_rnw[who], cur_sel[who], cur_addr[who], cur_data[who]});
    endtask

    task automatic expect_rsp(input int who, input logic ack, input logic rdv, input logic [31:0] d);
        exp_rsp_q.push_back(rsp_exp_t'{1'(who), ack, rdv, d});
    endtask

    task automatic wait_ds();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ds_v && n < 20);
        if (!ds_v) begin
            checks++; errors++;
            $display("FAIL wait_ds: downstream valid not seen within 20 cycles, got 0 expected 1");
        end
    endtask

    task automatic do_txn(input int who, input logic rnw, input logic [15:0] sel,
                          input logic [15:0] addr, input logic [31:0] data,
                          input int ack_dly, input int rdv_dly, input logic [31:0] rdata);
        set_req(who, rnw, sel, addr, data);
        expect_req(who);
        if (rnw && rdv_dly == 0) begin
            expect_rsp(who, 1'b1, 1'b1, rdata);
        end else begin
            expect_rsp(who, 1'b1, 1'b0, 32'h0);
            if (rnw) expect_rsp(who, 1'b0, 1'b1, rdata);
        end
        wait_ds();
        repeat (ack_dly) @(posedge clk);
        #1 bbc_ack = 1'b1;
        if (rnw && rdv_dly == 0) begin bbc_rdv = 1'b1; bbc_rdata = rdata; end
        @(posedge clk); #1 bbc_ack = 1'b0; bbc_rdv = 1'b0; drop_req(who);
        if (rnw && rdv_dly > 0) begin
            @(negedge clk);
            check("wait_data_busy", 96'(busy), 96'(1'b1));
            check("wait_data_ds_valid", 96'(ds_v), 96'(1'b0));
            repeat (rdv_dly - 1) @(posedge clk);
            #1 bbc_rdv = 1'b1; bbc_rdata = rdata;
            @(posedge clk); #1 bbc_rdv = 1'b0;
        end
        @(negedge clk);
        check("busy_falls", 96'(busy), 96'(1'b0));
    endtask

    // Monitor: new downstream request and every requester response pulse.
    always @(negedge clk) begin
        req_exp_t er;
        rsp_exp_t ep, ap;
        if (!reset) begin
            if (ds_v && !prev_ds_v) begin
                if (exp_req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ds_req: unexpected downstream request sel=%0h addr=%0h", ds_sel, ds_addr);
                end else begin
                    er = exp_req_q.pop_front();
                    check("ds_req", 96'(req_exp_t'{ds_rnw, ds_sel, ds_addr, ds_data}), 96'(er));
                end
            end
            if (r0_ack || r0_rdv || r1_ack || r1_rdv) begin
                check("rsp_exclusive", 96'((r0_ack || r0_rdv) && (r1_ack || r1_rdv)), 96'(1'b0));
                ap.who  = r1_ack || r1_rdv;
                ap.ack  = ap.who ? r1_ack : r0_ack;
                ap.rdv  = ap.who ? r1_rdv : r0_rdv;
                ap.data = ap.rdv ? (ap.who ? r1_rdata : r0_rdata) : 32'h0;
                if (exp_rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp: unexpected response got %0h, expected none", ap);
                end else begin
                    ep = exp_rsp_q.pop_front();
                    check("rsp", 96'(ap), 96'(ep));
                end
            end
        end
        prev_ds_v = ds_v;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        r0_v = 0; r0_rnw = 0; r0_sel = 0; r0_addr = 0; r0_data = 0;
        r1_v = 0; r1_rnw = 0; r1_sel = 0; r1_addr = 0; r1_data = 0;
        bbc_ack = 0; bbc_rdv = 0; bbc_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ds_valid", 96'(ds_v), 96'(1'b0));
        check("reset_busy", 96'(busy), 96'(1'b0));
        check("reset_ds_select", 96'(ds_sel), 96'(16'h0));
        check("reset_timeout_count", 96'(timeout_count), 96'(8'h0));
        check("reset_rsp", 96'({r0_ack, r0_rdv, r1_ack, r1_rdv}), 96'(4'h0));
        @(posedge clk); #1 reset = 1'b0;

        // Single write from req0, ack two cycles after downstream valid.
        do_txn(0, 1'b0, 16'h0001, 16'h0010, 32'h1234_5678, 2, 0, 32'h0);
        // Read from req1: ack at +1, read data at +4 through WAIT_DATA.
        do_txn(1, 1'b1, 16'h0002, 16'h0020, 32'h0000_0000, 1, 3, 32'hCAFE_F00D);

        // Continuous contention: grants must alternate 0,1,0,1,0,1.
        set_req(0, 1'b0, 16'h0100, 16'h0200, 32'hA000_0000);
        set_req(1, 1'b0, 16'h0101, 16'h0300, 32'hB000_0000);
        for (int i = 0; i < 6; i++) begin
            expect_req(i % 2);
            expect_rsp(i % 2, 1'b1, 1'b0, 32'h0);
            wait_ds();
            @(posedge clk); #1 bbc_ack = 1'b1;
            @(posedge clk); #1 bbc_ack = 1'b0;
            if (i == 5) begin
                drop_req(0); drop_req(1);
                @(negedge clk);
                check("contention_idle", 96'(busy), 96'(1'b0));
            end else begin
                drop_req(i % 2);
                @(posedge clk); #1
                set_req(i % 2, 1'b0, cur_sel[i % 2], cur_addr[i % 2], cur_data[i % 2] + 32'd1);
            end
        end

        // Read with ack and read data in the same cycle.
        do_txn(0, 1'b1, 16'h0003, 16'h0030, 32'h0, 1, 0, 32'h5A5A_0001);

        // Reset in WAIT_DATA abandons the read; req0 was granted last.
        set_req(0, 1'b1, 16'h0005, 16'h0050, 32'h0);
        expect_req(0);
        expect_rsp(0, 1'b1, 1'b0, 32'h0);
        wait_ds();
        @(posedge clk); #1 bbc_ack = 1'b1;
        @(posedge clk); #1 bbc_ack = 1'b0; drop_req(0);
        @(negedge clk);
        check("pre_reset_wait_busy", 96'(busy), 96'(1'b1));
        @(posedge clk); #1 reset = 1'b1;
        #1;
        check("midreset_ds_valid", 96'(ds_v), 96'(1'b0));
        check("midreset_busy", 96'(busy), 96'(1'b0));
        check("midreset_ds_address", 96'(ds_addr), 96'(16'h0));
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 bbc_rdv = 1'b1; bbc_rdata = 32'h7777_7777;
        @(posedge clk); #1 bbc_rdv = 1'b0;
        @(negedge clk);
        check("late_rdv_busy", 96'(busy), 96'(1'b0));
        set_req(0, 1'b0, 16'h0006, 16'h0060, 32'h6000_0006);
        set_req(1, 1'b0, 16'h0007, 16'h0070, 32'h7000_0007);
        expect_req(0);
        expect_rsp(0, 1'b1, 1'b0, 32'h0);
        wait_ds();
        @(posedge clk); #1 bbc_ack = 1'b1;
        @(posedge clk); #1 bbc_ack = 1'b0; drop_req(0); drop_req(1);
        @(negedge clk);
        check("post_reset_idle", 96'(busy), 96'(1'b0));

`ifdef CSR_REQUEST_ARBITER_TIMEOUT_EN
        // BBC never answers a read: forced completion on the 8th busy cycle.
        set_req(1, 1'b1, 16'h0008, 16'h0080, 32'h0);
        expect_req(1);
        expect_rsp(1, 1'b1, 1'b1, 32'hDEAD_C5A0);
        wait_ds();
        n = 1;
        while (!r1_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 96'(n), 96'(8));
        @(posedge clk); #1 drop_req(1);
        @(negedge clk);
        check("timeout_idle", 96'(busy), 96'(1'b0));
        check("timeout_count_one", 96'(timeout_count), 96'(8'd1));
        @(posedge clk); #1 bbc_ack = 1'b1; bbc_rdv = 1'b1; bbc_rdata = 32'h1111_2222;
        @(posedge clk); #1 bbc_ack = 1'b0; bbc_rdv = 1'b0;
        @(negedge clk);
        check("timeout_count_after_late", 96'(timeout_count), 96'(8'd1));
`else
        check("timeout_count_tied", 96'(timeout_count), 96'(8'd0));
`endif

        repeat (2) @(negedge clk);
        check("exp_req_drained", 96'(exp_req_q.size()), 96'(0));
        check("exp_rsp_drained", 96'(exp_rsp_q.size()), 96'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_request_arbiter.md
# csr_request_arbiter

Two-requester arbiter sharing the single `csr_request`/`csr_response` port of `bbc_micro_with_rams` between the boot/configuration sequencer (requester 0) and the debug host bridge (requester 1). Round-robin grant, one transaction in flight, registered downstream request, combinational response routing to the granted requester. Sits between `bbc_project` top-level control logic and the BBC CSR bus.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles without downstream ack or read data before forced completion (timeout build only). Range 1..65535.
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0_csr_request__valid / __read_not_write / __select / __address / __data`  in  1/1/16/16/32  requester 0 request
- `req0_csr_response__ack / __read_data_valid / __read_data`  out  1/1/32  requester 0 response
- `req1_csr_request__*`, `req1_csr_response__*`: same widths and directions as requester 0
- `csr_request__valid / __read_not_write / __select / __address / __data`  out  1/1/16/16/32  to BBC
- `csr_response__ack / __read_data_valid / __read_data`  in  1/1/32  from BBC
- `busy`  out  1  high in any state other than IDLE
- `timeout_count`  out  8  saturating count of timed-out transactions (timeout build only; constant 0 otherwise)

## Operation
- States: IDLE, ISSUE, WAIT_DATA.
- IDLE: if any requester valid, grant; capture its request fields into downstream registers; set `csr_request__valid`; go ISSUE. Both valid: grant the one not granted last (`last_grant` reset 1, so requester 0 wins first contention).
- ISSUE: hold all downstream request fields stable. On `csr_response__ack`: clear downstream valid; write -> IDLE; read with `read_data_valid` same cycle -> IDLE; read otherwise -> WAIT_DATA.
- WAIT_DATA: on `csr_response__read_data_valid` -> IDLE.
- Routing: granted requester's `ack` = downstream ack while in ISSUE; `read_data_valid` = downstream read_data_valid while in ISSUE (read) or WAIT_DATA; `read_data` driven to both requesters unconditionally. Non-granted requester sees 0 on ack/read_data_valid.
- Downstream ack/read_data_valid in IDLE: ignored, not routed.
- Requester valid changes after grant are ignored until next IDLE; requester must hold valid until ack and drop it the cycle after ack.
- `last_grant` updates on grant.
- Reset (any time, including mid-transaction): state IDLE, all downstream request outputs 0, `last_grant` 1, `timeout_count` 0, response outputs 0; in-flight transaction abandoned.

## Timing
- Requester valid sampled at edge E -> downstream valid high from E (cycle after request).
- Minimum write: request cycle N, downstream valid N+1, ack in N+1 -> requester ack in N+1, IDLE at N+2, next grant sampled at end of N+2, downstream valid N+3.
- Back-to-back contention alternates grants; no requester waits more than one transaction.
- No combinational path from requester inputs to downstream outputs; response paths are combinational (downstream -> requester) gated by registered state.

## Configuration
- `CSR_REQUEST_ARBITER_TIMEOUT_EN` defined: 16-bit counter cleared on grant, increments in ISSUE/WAIT_DATA; on reaching `TIMEOUT_CYCLES` with no completion, arbiter drives ack (if in ISSUE) and, for reads, read_data_valid with read_data 32'hDEAD_C5A0 to the granted requester in that cycle, clears downstream valid, goes IDLE, increments `timeout_count` (saturates at 255). Late downstream responses then arrive in IDLE and are dropped.
- Not defined: no counter, no forced completion, `timeout_count` tied 0; arbiter waits indefinitely.

## Structure
- Shared package `bbc_csr_pkg`: state enum (IDLE, ISSUE, WAIT_DATA), request/response struct widths, timeout read-data constant 32'hDEAD_C5A0.
- One sub-module: `csr_arb_timeout` (counter, compare, saturating `timeout_count`), instantiated only under the macro.

## Test plan
- Single write from req0 (select 16'h0001, address 16'h0010, data 32'h1234_5678), BBC acks 2 cycles after valid -> downstream fields match exactly, req0 ack one cycle, req1 sees no ack, busy falls next cycle.
- Read from req1, ack at cycle +1, read_data_valid 32'hCAFE_F00D at +4 -> req1 read_data_valid one cycle with that data, state passes through WAIT_DATA.
- Both requesters valid continuously for 6 transactions -> grant order 0,1,0,1,0,1.
- Read with ack and read_data_valid in the same cycle -> direct ISSUE->IDLE, single read_data_valid pulse.
- Reset asserted in WAIT_DATA -> downstream valid 0 immediately, later read_data_valid ignored, next request granted to req0.
- Timeout build, TIMEOUT_CYCLES=8, BBC never acks a read -> req ack and read_data_valid with 32'hDEAD_C5A0 after 8 cycles, timeout_count=1.
